// File: rtl/step_gen_pkg.sv
// Shared types and constants for the step command generator: FSM state encoding,
// direction levels and constant width helpers.
package step_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FIRST    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_WAIT_REL = 3'd4
  } step_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int count_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output level only follows the
// synchronised button after DEB_CYCLES consecutive samples that disagree with it.
module btn_debounce
  import step_gen_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CNT_W = count_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      // A sample that agrees with the current level is a bounce: start counting again.
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_cmd_generator.sv
// Turns two raw push-buttons into a one-cycle step_en pulse plus a direction level.
// Define STEP_AUTOREPEAT_EN to enable timed auto-repeat while a button is held.
module step_cmd_generator
  import step_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic stepClk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic step_en,
  output logic up_down,
  output logic busy
);

  if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("step_cmd_generator: illegal DEB/HOLD/REPEAT parameter values");
  end

  step_state_e state;
  step_state_e state_next;
  logic        deb_up;
  logic        deb_down;
  logic        both_high;
  logic        one_high;
  logic        none_high;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (stepClk),
    .reset (reset),
    .btn   (btn_up),
    .level (deb_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk   (stepClk),
    .reset (reset),
    .btn   (btn_down),
    .level (deb_down)
  );

  always_comb begin
    both_high = deb_up & deb_down;
    one_high  = deb_up ^ deb_down;
    none_high = ~(deb_up | deb_down);
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam int TIMER_W = count_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

  logic [TIMER_W-1:0] timer;
  logic               held;
  logic               step_ok;
  logic               timer_hit;

  always_comb begin
    held      = (up_down == DIR_UP) ? deb_up : deb_down;
    step_ok   = held & ~both_high;
    timer_hit = ((state == ST_HOLD)   && (timer == HOLD_LAST)) ||
                ((state == ST_REPEAT) && (timer == REPEAT_LAST));
  end

  // Timer runs only while a press is being held; it restarts on each pulse and saturates.
  always_ff @(posedge stepClk) begin
    if (reset) begin
      timer <= '0;
    end else if (((state != ST_HOLD) && (state != ST_REPEAT)) || timer_hit) begin
      timer <= '0;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + TIMER_W'(1);
    end
  end
`endif

  always_ff @(posedge stepClk) begin
    if (reset) begin
      state   <= ST_IDLE;
      up_down <= DIR_DOWN;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && (state_next == ST_FIRST)) begin
        up_down <= deb_up ? DIR_UP : DIR_DOWN;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (both_high)     state_next = ST_WAIT_REL;
        else if (one_high) state_next = ST_FIRST;
      end
`ifdef STEP_AUTOREPEAT_EN
      ST_FIRST: state_next = ST_HOLD;
      ST_HOLD, ST_REPEAT: begin
        if (both_high)                           state_next = ST_WAIT_REL;
        else if (!held)                          state_next = ST_IDLE;
        else if ((state == ST_HOLD) && timer_hit) state_next = ST_REPEAT;
      end
`else
      ST_FIRST: state_next = ST_WAIT_REL;
`endif
      // Only a full release re-arms, so dropping one of two buttons never steps.
      ST_WAIT_REL: if (none_high) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
`ifdef STEP_AUTOREPEAT_EN
    step_en = (state == ST_FIRST) || (timer_hit && step_ok);
`else
    step_en = (state == ST_FIRST);
`endif
  end

endmodule

// File: tb/tb_step_cmd_generator.sv
// Self-checking bench for step_cmd_generator: directed scenarios plus random button
// activity, all checked cycle by cycle against a press-age reference model.
module tb_step_cmd_generator;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
`ifdef STEP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int M_FREE  = 0;
  localparam int M_PRESS = 1;
  localparam int M_LOCK  = 2;

  logic stepClk  = 1'b0;
  logic reset    = 1'b0;
  logic btn_up   = 1'b0;
  logic btn_down = 1'b0;
  logic step_en;
  logic up_down;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a press is tracked by its age in cycles since the first step.
  int m_mode = M_FREE;
  int m_age  = 0;
  bit m_dir  = 1'b0;
  bit m_lu   = 1'b0;
  bit m_ld   = 1'b0;
  bit raw_u[$];
  bit raw_d[$];
  bit seen_u[$];
  bit seen_d[$];
  bit exp_step = 1'b0;
  bit exp_dir  = 1'b0;
  bit exp_busy = 1'b0;

  step_cmd_generator #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .stepClk  (stepClk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .step_en  (step_en),
    .up_down  (up_down),
    .busy     (busy)
  );

  always #5 stepClk = ~stepClk;

  // Level flips once the last DEB samples all disagree with it.
  function automatic bit settle(input bit q[$], input bit lvl);
    if (q.size() < DEB) return lvl;
    for (int i = q.size() - DEB; i < q.size(); i++) begin
      if (q[i] == lvl) return lvl;
    end
    return !lvl;
  endfunction

  task automatic model_edge(input bit u, input bit d, input bit r);
    bit held_p;
    bit held_n;
    bit other_n;
    if (r) begin
      raw_u.delete(); raw_d.delete(); seen_u.delete(); seen_d.delete();
      m_mode = M_FREE; m_age = 0; m_dir = 1'b0; m_lu = 1'b0; m_ld = 1'b0;
    end else begin
      held_p = m_dir ? m_lu : m_ld;
      case (m_mode)
        M_FREE: begin
          if (m_lu && m_ld) m_mode = M_LOCK;
          else if (m_lu || m_ld) begin m_mode = M_PRESS; m_age = 0; m_dir = m_lu; end
        end
        M_PRESS: begin
          if (m_age == 0 && !AR)  m_mode = M_LOCK;
          else if (m_age == 0)    m_age = 1;
          else if (m_lu && m_ld)  m_mode = M_LOCK;
          else if (!held_p)       m_mode = M_FREE;
          else                    m_age++;
        end
        default: if (!m_lu && !m_ld) m_mode = M_FREE;
      endcase
      // Two synchroniser stages: the debouncer sees the raw level from three cycles back.
      raw_u.push_back(u); raw_d.push_back(d);
      if (raw_u.size() > 3) begin void'(raw_u.pop_front()); void'(raw_d.pop_front()); end
      seen_u.push_back(raw_u.size() == 3 ? raw_u[0] : 1'b0);
      seen_d.push_back(raw_d.size() == 3 ? raw_d[0] : 1'b0);
      if (seen_u.size() > DEB) begin void'(seen_u.pop_front()); void'(seen_d.pop_front()); end
      m_lu = settle(seen_u, m_lu);
      m_ld = settle(seen_d, m_ld);
    end
    held_n  = m_dir ? m_lu : m_ld;
    other_n = m_dir ? m_ld : m_lu;
    exp_step = (m_mode == M_PRESS) &&
               ((m_age == 0) ||
                (AR && held_n && !other_n && m_age >= HOLD && ((m_age - HOLD) % REP) == 0));
    exp_dir  = m_dir;
    exp_busy = (m_mode != M_FREE);
  endtask

  task automatic tick(input bit u, input bit d, input bit r);
    btn_up   = u;
    btn_down = d;
    reset    = r;
    @(posedge stepClk);
    model_edge(u, d, r);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({step_en, up_down, busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset cyc=%0d {step_en,up_down,busy}=%b want 000", cyc, {step_en, up_down, busy});
      end
    end
  endtask

  task automatic test_single_press();
    int pulses[$];
    for (int i = 1; i <= 30; i++) begin
      tick(i <= 5, 1'b0, 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL single_press cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
      if (step_en === 1'b1) begin
        pulses.push_back(i);
        n_cmp++;
        if (up_down !== 1'b1) begin n_bad++; $display("FAIL single_press_dir up_down=%b want 1", up_down); end
      end
    end
    n_cmp++;
    if (pulses.size() != 1 || pulses[0] != DEB + 3) begin
      n_bad++;
      $display("FAIL single_press_timing pulses=%p want '{%0d}", pulses, DEB + 3);
    end
  endtask

  task automatic test_bounce();
    int pulses[$];
    bit d;
    for (int i = 1; i <= 40; i++) begin
      d = (i <= 10) ? (((i - 1) / 2) % 2 == 0) : (i <= 20);
      tick(1'b0, d, 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL bounce cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
      if (step_en === 1'b1) begin
        pulses.push_back(i);
        n_cmp++;
        if (up_down !== 1'b0) begin n_bad++; $display("FAIL bounce_dir up_down=%b want 0", up_down); end
      end
    end
    n_cmp++;
    if (pulses.size() != 1 || pulses[0] != 15) begin
      n_bad++;
      $display("FAIL bounce_timing pulses=%p want '{15}", pulses);
    end
  endtask

  task automatic test_long_hold();
    int pulses[$];
    int want[$];
    if (AR) want = '{7, 27, 35, 43, 51, 59};
    else    want = '{7};
    for (int i = 1; i <= 85; i++) begin
      tick(i <= 60, 1'b0, 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL long_hold cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
      if (step_en === 1'b1) pulses.push_back(i);
    end
    n_cmp++;
    if (pulses.size() != want.size()) begin
      n_bad++;
      $display("FAIL long_hold_count pulses=%p want %p", pulses, want);
    end else begin
      foreach (want[j]) begin
        n_cmp++;
        if (pulses[j] != want[j]) begin
          n_bad++;
          $display("FAIL long_hold_pulse%0d at=%0d want %0d", j, pulses[j], want[j]);
        end
      end
    end
  endtask

  task automatic test_both_buttons();
    int pulses[$];
    for (int i = 1; i <= 60; i++) begin
      tick(i <= 25, (i >= 16) && (i <= 40), 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL both_buttons cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
      if (step_en === 1'b1) pulses.push_back(i);
      if (i == 40) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL both_busy_held busy=%b want 1", busy); end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL both_busy_released busy=%b want 0", busy); end
    n_cmp++;
    if (pulses.size() != 1 || pulses[0] != 7) begin
      n_bad++;
      $display("FAIL both_pulses pulses=%p want '{7}", pulses);
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses[$];
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL reset_mid_pre cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({step_en, up_down, busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_mid_clear cyc=%0d got %b want 000", cyc, {step_en, up_down, busy});
      end
    end
    for (int i = 1; i <= 32; i++) begin
      tick(i <= 12, 1'b0, 1'b0);
      n_cmp++;
      if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
        n_bad++;
        $display("FAIL reset_mid_post cyc=%0d got %b want %b", cyc, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
      end
      if (step_en === 1'b1) pulses.push_back(i);
    end
    n_cmp++;
    if (pulses.size() != 1 || pulses[0] != DEB + 3) begin
      n_bad++;
      $display("FAIL reset_mid_latency pulses=%p want '{%0d}", pulses, DEB + 3);
    end
  endtask

  task automatic test_random();
    int len;
    int kind;
    bit u;
    bit d;
    bit r;
    for (int seg = 0; seg < 120; seg++) begin
      kind = $urandom_range(0, 9);
      len  = (kind >= 8) ? $urandom_range(40, 80) : $urandom_range(1, 25);
      u    = 1'($urandom_range(0, 1));
      d    = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        r = (kind == 0) && (i < 2);
        if (kind == 1) begin
          u = 1'($urandom_range(0, 1));
          d = 1'($urandom_range(0, 1));
        end
        tick(u, d, r);
        n_cmp++;
        if ({step_en, up_down, busy} !== {exp_step, exp_dir, exp_busy}) begin
          n_bad++;
          $display("FAIL random cyc=%0d u=%b d=%b r=%b got %b want %b", cyc, u, d, r, {step_en, up_down, busy}, {exp_step, exp_dir, exp_busy});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_long_hold();
    test_both_buttons();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
